// File: rtl/id_regfile_sb.sv
// ID-stage register file: write-through bypass from WB plus a per-register pending-write
// scoreboard driving the decode stall. Optional macro ID_PC_READ_EN maps the top register to pc_in+8.
module id_regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic                         hazard,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_dest,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         iss_valid,
    input  logic                         iss_wb_en,
    input  logic [ADDR_W-1:0]            iss_dest,
    input  logic                         flush,
    input  logic [DATA_W-1:0]            pc_in,
    output logic                         sb_err
);

    localparam int unsigned       NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_REG  = ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

`ifdef ID_PC_READ_EN
    localparam bit PC_MAP = 1'b1;
    logic [DATA_W-1:0] pc_val;
    assign pc_val = pc_in + DATA_W'(8);
`else
    localparam bit PC_MAP = 1'b0;
    logic [DATA_W-1:0] pc_val;
    logic              unused_pc;
    assign pc_val    = '0;
    assign unused_pc = ^pc_in;
`endif

    logic [DATA_W-1:0]   regs    [NUM_REGS];
    logic [CNT_W-1:0]    cnt     [NUM_REGS];
    logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
    logic [ADDR_W-1:0]   rd_a    [RD_PORTS];
    logic [RD_PORTS-1:0] rd_pend;
    logic [NUM_REGS-1:0] inc_v;
    logic [NUM_REGS-1:0] dec_v;
    logic                wb_eff;
    logic                iss_acc;
    logic                err_set;

    // Writes aimed at the PC alias are dropped when that mapping is enabled
    assign wb_eff = wb_en && !(PC_MAP && (wb_dest == TOP_REG));

    always_comb begin
        for (int i = 0; i < RD_PORTS; i++) begin
            rd_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Read mux with zero-latency bypass; a port stalls only if writes remain after this WB
    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (PC_MAP && (rd_a[i] == TOP_REG)) begin
                rd_data[i*DATA_W +: DATA_W] = pc_val;
            end else begin
                if (wb_eff && (wb_dest == rd_a[i])) begin
                    rd_data[i*DATA_W +: DATA_W] = wb_data;
                end else begin
                    rd_data[i*DATA_W +: DATA_W] = regs[rd_a[i]];
                end
                rd_pend[i] = rd_en[i] &&
                             (cnt[rd_a[i]] > CNT_W'(wb_eff && (wb_dest == rd_a[i])));
            end
        end
    end

    assign hazard = |rd_pend;

    assign iss_acc = iss_valid && iss_wb_en && !hazard && !flush &&
                     !(PC_MAP && (iss_dest == TOP_REG));

    // Scoreboard next state: flush wins, matched inc/dec cancel, saturation flags an error
    always_comb begin
        inc_v   = '0;
        dec_v   = '0;
        err_set = 1'b0;
        for (int a = 0; a < NUM_REGS; a++) begin
            inc_v[a]   = iss_acc && (iss_dest == ADDR_W'(a));
            dec_v[a]   = wb_eff && (wb_dest == ADDR_W'(a)) && (cnt[a] != '0);
            cnt_nxt[a] = cnt[a];
            if (flush) begin
                cnt_nxt[a] = '0;
            end else if (inc_v[a] && !dec_v[a]) begin
                if (cnt[a] == CNT_MAX) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[a] = cnt[a] + CNT_W'(1);
                end
            end else if (dec_v[a] && !inc_v[a]) begin
                cnt_nxt[a] = cnt[a] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                regs[a] <= '0;
            end
        end else if (wb_eff) begin
            regs[wb_dest] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                cnt[a] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int a = 0; a < NUM_REGS; a++) begin
                cnt[a] <= cnt_nxt[a];
            end
            if (err_set) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Bench for id_regfile_sb: directed vector table, an async-reset corner sequence,
// then randomized traffic checked against a behavioural scoreboard model.
module tb_id_regfile_sb;

    localparam int NR   = 16;
    localparam int CMAX = 3;
`ifdef ID_PC_READ_EN
    localparam bit PC_MODE = 1'b1;
`else
    localparam bit PC_MODE = 1'b0;
`endif
    localparam logic [31:0] R15_A = PC_MODE ? 32'h108 : 32'h0;
    localparam logic [31:0] R15_B = PC_MODE ? 32'h108 : 32'h55;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  rd_en = '0;
    logic [7:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        hazard;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic [31:0] wb_data = '0;
    logic        iss_valid = 1'b0;
    logic        iss_wb_en = 1'b0;
    logic [3:0]  iss_dest = '0;
    logic        flush = 1'b0;
    logic [31:0] pc_in = 32'h100;
    logic        sb_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_regfile_sb dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .hazard(hazard), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_wb_en(iss_wb_en), .iss_dest(iss_dest),
        .flush(flush), .pc_in(pc_in), .sb_err(sb_err)
    );

    typedef struct {
        logic [1:0]  en;
        logic [3:0]  a0, a1;
        logic        wbe;
        logic [3:0]  wbd;
        logic [31:0] wbv;
        logic        iv, iwb;
        logic [3:0]  id;
        logic        fl;
        logic [31:0] e0, e1;
        logic        eh, ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] en, input int a0, input int a1,
                       input logic wbe, input int wbd, input logic [31:0] wbv,
                       input logic iv, input logic iwb, input int id, input logic fl,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic eh, input logic ee);
        vec_t v;
        v.en = en; v.a0 = 4'(a0); v.a1 = 4'(a1); v.wbe = wbe; v.wbd = 4'(wbd); v.wbv = wbv;
        v.iv = iv; v.iwb = iwb; v.id = 4'(id); v.fl = fl;
        v.e0 = e0; v.e1 = e1; v.eh = eh; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: register contents and outstanding-write counts as plain ints
    logic [31:0] m_regs [NR];
    int          m_cnt  [NR];
    bit          m_err;

    function automatic bit is_pc(input int a);
        return PC_MODE && (a == NR - 1);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (is_pc(a)) return pc_in + 32'd8;
        if (wb_en && int'(wb_dest) == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_hazard();
        for (int i = 0; i < 2; i++) begin
            int a = int'(rd_addr[i*4 +: 4]);
            int left = m_cnt[a] - ((wb_en && int'(wb_dest) == a) ? 1 : 0);
            if (rd_en[i] && !is_pc(a) && left > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int a = 0; a < NR; a++) begin
            m_regs[a] = '0;
            m_cnt[a]  = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic m_update();
        bit haz = m_hazard();
        int net;
        if (wb_en && !is_pc(int'(wb_dest))) m_regs[wb_dest] = wb_data;
        for (int a = 0; a < NR; a++) begin
            if (flush) begin
                m_cnt[a] = 0;
            end else begin
                net = 0;
                if (iss_valid && iss_wb_en && !haz && int'(iss_dest) == a && !is_pc(a)) net++;
                if (wb_en && !is_pc(a) && int'(wb_dest) == a && m_cnt[a] > 0) net--;
                if (net > 0 && m_cnt[a] == CMAX) m_err = 1'b1;
                else m_cnt[a] = m_cnt[a] + net;
            end
        end
    endtask

    function automatic logic [3:0] rnd_addr();
        return ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        m_reset();
        // Directed vectors: rd0, rd1, hazard checked before the edge; sb_err reflects prior edges
        //   en    a0  a1  wbe wbd wbv           iv iwb id fl e0            e1            eh ee
        add(2'b11, 3, 15, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        R15_A,        0, 0);
        add(2'b01, 5, 0,  1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0);
        add(2'b01, 5, 0,  0, 0, 32'h0,        0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0);
        add(2'b00, 2, 0,  0, 0, 32'h0,        1, 1, 2, 0, 32'h0,        32'h0,        0, 0);
        add(2'b01, 2, 0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        1, 0);
        add(2'b01, 2, 0,  1, 2, 32'h1234,     0, 0, 0, 0, 32'h1234,     32'h0,        0, 0);
        add(2'b01, 2, 0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h1234,     32'h0,        0, 0);
        for (int k = 0; k < 4; k++)
            add(2'b00, 7, 0, 0, 0, 32'h0,     1, 1, 7, 0, 32'h0,        32'h0,        0, 0);
        add(2'b01, 7, 0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        1, 1);
        add(2'b00, 0, 0,  0, 0, 32'h0,        1, 1, 4, 0, 32'h0,        32'h0,        0, 1);
        add(2'b00, 4, 0,  0, 0, 32'h0,        1, 1, 4, 1, 32'h0,        32'h0,        0, 1);
        add(2'b11, 4, 7,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 1);
        add(2'b01, 4, 0,  1, 4, 32'hA5A5A5A5, 0, 0, 0, 0, 32'hA5A5A5A5, 32'h0,        0, 1);
        add(2'b11, 4, 5,  0, 0, 32'h0,        0, 0, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 1);
        add(2'b00, 0, 0,  0, 0, 32'h0,        1, 1, 9, 0, 32'h0,        32'h0,        0, 1);
        add(2'b00, 9, 0,  1, 9, 32'h99,       1, 1, 9, 0, 32'h99,       32'h0,        0, 1);
        add(2'b01, 9, 0,  0, 0, 32'h0,        1, 1, 10, 0, 32'h99,      32'h0,        1, 1);
        add(2'b01, 9, 0,  1, 9, 32'h77,       0, 0, 0, 0, 32'h77,       32'h0,        0, 1);
        add(2'b01, 10, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 1);
        add(2'b00, 0, 0,  0, 0, 32'h0,        1, 0, 11, 0, 32'h0,       32'h0,        0, 1);
        add(2'b01, 11, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 1);
        add(2'b10, 0, 15, 1, 15, 32'h55,      0, 0, 0, 0, 32'h0,        R15_B,        0, 1);
        add(2'b10, 0, 15, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        R15_B,        0, 1);
        add(2'b00, 0, 15, 0, 0, 32'h0,        1, 1, 15, 0, 32'h0,       R15_B,        0, 1);
        add(2'b10, 0, 15, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        R15_B,        !PC_MODE, 1);
        add(2'b00, 0, 0,  0, 0, 32'h0,        1, 1, 5, 0, 32'h0,        32'h0,        0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            rd_en = tbl[k].en; rd_addr = {tbl[k].a1, tbl[k].a0};
            wb_en = tbl[k].wbe; wb_dest = tbl[k].wbd; wb_data = tbl[k].wbv;
            iss_valid = tbl[k].iv; iss_wb_en = tbl[k].iwb; iss_dest = tbl[k].id;
            flush = tbl[k].fl;
            @(negedge clk);
            check($sformatf("v%0d.rd0", k), rd_data[31:0], tbl[k].e0);
            check($sformatf("v%0d.rd1", k), rd_data[63:32], tbl[k].e1);
            check($sformatf("v%0d.hazard", k), 32'(hazard), 32'(tbl[k].eh));
            check($sformatf("v%0d.sb_err", k), 32'(sb_err), 32'(tbl[k].ee));
            @(posedge clk);
            #1;
        end

        // Async reset between edges must clear data, scoreboard and error at once
        rd_en = 2'b01; rd_addr = 8'h05; wb_en = 1'b0; iss_valid = 1'b0; flush = 1'b0;
        #2;
        check("pre_rst.hazard", 32'(hazard), 32'd1);
        check("pre_rst.rd0", rd_data[31:0], 32'hDEADBEEF);
        rst = 1'b0;
        #1;
        check("mid_rst.hazard", 32'(hazard), 32'd0);
        check("mid_rst.rd0", rd_data[31:0], 32'h0);
        check("mid_rst.sb_err", 32'(sb_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst = 1'b0;
                m_reset();
                #2;
                rst = 1'b1;
            end
            rd_en     = 2'($urandom);
            rd_addr   = {rnd_addr(), rnd_addr()};
            wb_en     = 1'($urandom_range(0, 1));
            wb_dest   = rnd_addr();
            wb_data   = $urandom;
            iss_valid = ($urandom_range(0, 3) != 0);
            iss_wb_en = ($urandom_range(0, 4) != 0);
            iss_dest  = rnd_addr();
            flush     = ($urandom_range(0, 31) == 0);
            pc_in     = $urandom;
            @(negedge clk);
            check($sformatf("rnd%0d.rd0", n), rd_data[31:0], m_read(int'(rd_addr[3:0])));
            check($sformatf("rnd%0d.rd1", n), rd_data[63:32], m_read(int'(rd_addr[7:4])));
            check($sformatf("rnd%0d.hazard", n), 32'(hazard), 32'(m_hazard()));
            check($sformatf("rnd%0d.sb_err", n), 32'(sb_err), 32'(m_err));
            m_update();
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_regfile_sb.md
Name: id_regfile_sb

Overview:
- Parametrised successor to the decode-stage register file. Multi-port register file with write-through bypass from writeback.
- Per-register pending-write scoreboard that raises a decode hazard/stall.
- Sits in the ID stage. Read ports feed val_Rn/val_Rm-style operands; writeback port comes from the WB stage; issue port comes from the ID/EXE boundary.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W.
- RD_PORTS, 2, number of combinational read ports.
- CNT_W, 2, width of each register's pending-write counter; max in-flight writes per register = 2**CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- rd_en  in  RD_PORTS  per-port read enable; only affects hazard, data is always driven.
- rd_addr  in  RD_PORTS*ADDR_W  flattened read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  RD_PORTS*DATA_W  flattened read data, combinational.
- hazard  out  1  combinational stall request to ID.
- wb_en  in  1  writeback write enable.
- wb_dest  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback data.
- iss_valid  in  1  an instruction leaves ID this cycle.
- iss_wb_en  in  1  the issuing instruction will write back.
- iss_dest  in  ADDR_W  destination of the issuing instruction.
- flush  in  1  squash all in-flight writes; clears scoreboard.
- pc_in  in  DATA_W  current-instruction PC; used only with the optional feature.
- sb_err  out  1  sticky scoreboard error flag.

Behaviour:
- Reset (rst=0, async): all registers 0, all counters 0, sb_err 0. rd_data then reads 0 unless bypassed; hazard 0.
- Write: at posedge, if wb_en, regs[wb_dest] <= wb_data. A write is never blocked by flush or hazard.
- Read: rd_data[i] = wb_data if (wb_en && wb_dest==rd_addr[i]), else regs[rd_addr[i]]. Write-through is zero latency and applies to all ports independently.
- Effective pending for address a: eff(a) = cnt[a] - (wb_en && wb_dest==a ? 1 : 0), floored at 0.
- hazard = OR over i of (rd_en[i] && eff(rd_addr[i]) != 0). It is independent of iss_valid.
- Issue accepted: acc = iss_valid && iss_wb_en && !hazard && !flush.
- Counter update at posedge, per register a, priority order:
  1. flush=1: cnt[a] <= 0. Writeback data still commits.
  2. Otherwise inc = acc && iss_dest==a, dec = wb_en && wb_dest==a && cnt[a]!=0.
     - inc&&dec: no change.
     - inc only: +1. If cnt[a] is already at max, hold and set sb_err.
     - dec only: -1.
- Writeback to a register with cnt==0 (post-flush straggler or untracked write): data commits, counter stays 0, no error.
- sb_err is sticky until reset.
- Issue while hazard=1 is ignored (not counted); ID is responsible for holding.
- Reset mid-operation: immediate clear of all state, regardless of clk.

Optional Feature:
- Macro ID_PC_READ_EN.
- Defined:
  - Reads of address NUM_REGS-1 return pc_in+8 (DATA_W wrap-around).
  - Writes to NUM_REGS-1 are discarded.
  - No bypass and never a hazard on that address.
  - Issues with iss_dest=NUM_REGS-1 are not counted.
- Undefined: NUM_REGS-1 is an ordinary register; pc_in is unused.

Test Plan:
- Reset then read r3, r15 with rd_en=11 -> rd_data 0/0, hazard 0, sb_err 0.
- wb_en=1, wb_dest=5, wb_data=0xDEADBEEF while rd_addr0=5 -> rd_data0=0xDEADBEEF in the same cycle; after the edge, with wb_en=0, still 0xDEADBEEF.
- Issue dest=2, then read r2 with rd_en=1 -> hazard=1. Assert wb to r2 -> hazard drops the same cycle, data is bypassed, and cnt[2]=0 after the edge.
- With CNT_W=2, issue dest=7 three times, then a fourth issue (rd_en=0) -> cnt holds at 3 and sb_err=1 permanently.
- Issue dest=4, then flush=1 concurrently with iss_valid dest=4 -> cnt[4]=0 and the issue is not counted. A later wb to r4 commits data, cnt stays 0, no error.
- ID_PC_READ_EN defined, pc_in=0x100, rd_addr=15 -> rd_data=0x108; a wb to r15 of 0x55 followed by a read -> still pc_in+8.
